// File: rtl/on_off_pkg.sv
// Shared types and default constants for the armed/disarmed flag block.
package on_off_pkg;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    localparam int unsigned DEF_LOCKOUT_CYCLES = 0;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;
    localparam int unsigned DEF_CNT_W          = 32;

endpackage

// File: rtl/on_off_countdown.sv
// Loadable down-counter that saturates at zero; zero reflects the registered count.
module on_off_countdown
    import on_off_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/on_off_state.sv
// Global armed/disarmed flag driven by gesture command strobes, with optional lockout.
// Define ON_OFF_AUTO_OFF_EN to add the inactivity auto-off while armed.
module on_off_state
    import on_off_pkg::*;
#(
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic is_on,
    input  logic is_off,
    output logic on_off_s,
    output logic turned_on,
    output logic turned_off
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (64'(LOCKOUT_CYCLES) > CNT_MAX || 64'(TIMEOUT_CYCLES) > CNT_MAX) begin : g_param_check
        $error("on_off_state: LOCKOUT_CYCLES/TIMEOUT_CYCLES do not fit in CNT_W");
    end

    state_t state_q, state_d;
    logic   turned_on_q, turned_on_d;
    logic   turned_off_q, turned_off_d;
    logic   lock_zero;
    logic   lock_load;
    logic   force_off;

    on_off_countdown #(.CNT_W(CNT_W)) u_lockout (
        .clock      (clock),
        .reset      (reset),
        .load       (lock_load),
        .load_value (CNT_W'(LOCKOUT_CYCLES)),
        .zero       (lock_zero)
    );

`ifdef ON_OFF_AUTO_OFF_EN
    logic idle_zero;
    logic idle_load;

    // Counting down from TIMEOUT-1 reaches zero exactly when an idle up-count would hit TIMEOUT-1.
    assign idle_load = turned_on_d || (state_q == ST_ON && is_on);
    assign force_off = (state_q == ST_ON) && idle_zero;

    on_off_countdown #(.CNT_W(CNT_W)) u_idle (
        .clock      (clock),
        .reset      (reset),
        .load       (idle_load),
        .load_value (CNT_W'(TIMEOUT_CYCLES - 1)),
        .zero       (idle_zero)
    );
`else
    assign force_off = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        turned_on_d  = 1'b0;
        turned_off_d = 1'b0;
        lock_load    = 1'b0;
        if (force_off) begin
            state_d      = ST_OFF;
            turned_off_d = 1'b1;
            lock_load    = 1'b1;
        end else if (lock_zero && (is_on ^ is_off)) begin
            if (state_q == ST_OFF && is_on) begin
                state_d     = ST_ON;
                turned_on_d = 1'b1;
                lock_load   = 1'b1;
            end else if (state_q == ST_ON && is_off) begin
                state_d      = ST_OFF;
                turned_off_d = 1'b1;
                lock_load    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_OFF;
            turned_on_q  <= 1'b0;
            turned_off_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            turned_on_q  <= turned_on_d;
            turned_off_q <= turned_off_d;
        end
    end

    assign on_off_s   = (state_q == ST_ON);
    assign turned_on  = turned_on_q;
    assign turned_off = turned_off_q;

endmodule

// File: tb/tb_on_off_state.sv
// Bench for on_off_state: two instances (no lockout, lockout of 4) checked against a rule-level model.
module tb_on_off_state;

    localparam int TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic is_on = 1'b0;
    logic is_off = 1'b0;
    logic s0, on0, off0, s4, on4, off4;

    int checks = 0;
    int passed = 0;

    int lock_len [2] = '{0, 4};
    bit m_st   [2];
    int m_lock [2];
    int m_idle [2];
    bit m_on   [2];
    bit m_off  [2];

    always #5 clock = ~clock;

    on_off_state #(.LOCKOUT_CYCLES(0), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(32)) dut0 (
        .clock(clock), .reset(reset), .is_on(is_on), .is_off(is_off),
        .on_off_s(s0), .turned_on(on0), .turned_off(off0)
    );

    on_off_state #(.LOCKOUT_CYCLES(4), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(32)) dut4 (
        .clock(clock), .reset(reset), .is_on(is_on), .is_off(is_off),
        .on_off_s(s4), .turned_on(on4), .turned_off(off4)
    );

    function automatic logic [2:0] obs(input int k);
        return (k == 0) ? {s0, on0, off0} : {s4, on4, off4};
    endfunction

    function automatic logic [2:0] expv(input int k);
        return {m_st[k], m_on[k], m_off[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_lock[k] = 0; m_idle[k] = 0; m_on[k] = 0; m_off[k] = 0;
        end
    endtask

    // One rising edge of the rules: accept a lone command only when the lockout has expired.
    task automatic model_edge(input bit on, input bit off);
        for (int k = 0; k < 2; k++) begin
            bit go_on, go_off;
            go_on  = !m_st[k] && on && !off && (m_lock[k] == 0);
            go_off = m_st[k] && off && !on && (m_lock[k] == 0);
`ifdef ON_OFF_AUTO_OFF_EN
            if (m_st[k] && m_idle[k] == TIMEOUT - 1) begin
                go_on = 0; go_off = 1;
            end
`endif
            m_on[k] = go_on;
            m_off[k] = go_off;
            if (go_on || go_off) begin
                m_st[k] = go_on;
                m_lock[k] = lock_len[k];
                m_idle[k] = 0;
            end else begin
                if (m_lock[k] > 0) m_lock[k] = m_lock[k] - 1;
                if (m_st[k]) m_idle[k] = on ? 0 : m_idle[k] + 1;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit on, input bit off);
        is_on = on;
        is_off = off;
        @(posedge clock);
        model_edge(on, off);
        @(negedge clock);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        model_reset();
        is_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== 3'b000) $display("FAIL reset_hold dut%0d: got %b want 000", k, obs(k));
                else passed++;
            end
        end
        is_on = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) $display("FAIL reset_release dut%0d: got %b want %b", k, obs(k), expv(k));
                else passed++;
            end
        end
    endtask

    task automatic test_turn_on();
        for (int i = 0; i < 3; i++) begin
            cycle(i == 0, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) $display("FAIL turn_on dut%0d cyc%0d: got %b want %b", k, i, obs(k), expv(k));
                else passed++;
            end
        end
        checks++;
        if ({s0, on0, off0} !== 3'b100) $display("FAIL turn_on_hold: got %b want 100", {s0, on0, off0});
        else passed++;
    endtask

    task automatic test_off_on();
        int n_on = 0, n_off = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(i == 5, i == 0);
            n_on += on0;
            n_off += off0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) $display("FAIL off_on dut%0d cyc%0d: got %b want %b", k, i, obs(k), expv(k));
                else passed++;
            end
        end
        checks++;
        if (n_on !== 1 || n_off !== 1) $display("FAIL off_on_pulses: got on=%0d off=%0d want 1/1", n_on, n_off);
        else passed++;
    endtask

    task automatic test_conflict();
        bit seq_on  [6] = '{1, 0, 0, 0, 0, 0};
        bit seq_off [6] = '{1, 0, 0, 0, 0, 0};
        settle(6);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 6; i++) begin
                cycle(seq_on[i], seq_off[i]);
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs(k) !== expv(k)) $display("FAIL conflict dut%0d p%0d c%0d: got %b want %b", k, pass, i, obs(k), expv(k));
                    else passed++;
                end
            end
            cycle(!m_st[0], m_st[0]);
            settle(6);
        end
    endtask

    task automatic test_lockout();
        cycle(0, 1);
        settle(6);
        for (int i = 0; i < 7; i++) begin
            cycle(i == 0, i == 2 || i == 5);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) $display("FAIL lockout dut%0d cyc%0d: got %b want %b", k, i, obs(k), expv(k));
                else passed++;
            end
            if (i == 4) begin
                checks++;
                if (s4 !== 1'b1) $display("FAIL lockout_ignore: got %b want 1", s4);
                else passed++;
            end
            if (i == 5) begin
                checks++;
                if ({s4, off4} !== 2'b01) $display("FAIL lockout_accept: got %b want 01", {s4, off4});
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        settle(6);
        cycle(0, 1);
        settle(6);
        for (int i = 0; i < 4; i++) begin
            cycle(i % 2 == 0, i % 2 == 1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) $display("FAIL back_to_back dut%0d cyc%0d: got %b want %b", k, i, obs(k), expv(k));
                else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        settle(6);
        cycle(1, 0);
        cycle(0, 0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 3'b000) $display("FAIL async_reset dut%0d: got %b want 000", k, obs(k));
            else passed++;
        end
        @(negedge clock);
        reset = 1'b1;
        settle(2);
    endtask

`ifdef ON_OFF_AUTO_OFF_EN
    task automatic test_auto_off();
        cycle(0, 1);
        settle(6);
        cycle(1, 0);
        for (int i = 1; i <= 9; i++) begin
            cycle(0, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) $display("FAIL auto_off dut%0d cyc%0d: got %b want %b", k, i, obs(k), expv(k));
                else passed++;
            end
            if (i == 7 || i == 8) begin
                checks++;
                if ({s0, off0} !== ((i == 7) ? 2'b10 : 2'b01)) $display("FAIL auto_off_edge cyc%0d: got %b", i, {s0, off0});
                else passed++;
            end
        end
        settle(6);
        cycle(1, 0);
        settle(3);
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({s0, on0, off0} !== 3'b000) $display("FAIL auto_off_reset: got %b want 000", {s0, on0, off0});
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        settle(2);
    endtask
`else
    task automatic test_no_auto_off();
        settle(6);
        cycle(1, 0);
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            cycle(0, 0);
            checks++;
            if ({s0, off0} !== 2'b10) $display("FAIL no_auto_off cyc%0d: got %b want 10", i, {s0, off0});
            else passed++;
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            cycle(r < 3 || r == 9, (r >= 3 && r < 6) || r == 9);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) $display("FAIL random dut%0d cyc%0d: got %b want %b", k, i, obs(k), expv(k));
                else passed++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_turn_on();
        test_off_on();
        test_conflict();
        test_lockout();
        test_back_to_back();
        test_async_reset();
`ifdef ON_OFF_AUTO_OFF_EN
        test_auto_off();
`else
        test_no_auto_off();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
